// File: rtl/pc_gen_unit.sv
// pc_gen_unit: fetch-stage program counter.
// Holds the PC and chooses the next one by priority:
// trap > jump > branch > stall > sequential.
// After an accepted redirect it inserts flush bubbles.
// It also handles halt/resume and rejects misaligned jump or branch targets.
module pc_gen_unit #(
    parameter int unsigned     XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter int unsigned     INST_BYTES   = 4,
    parameter int unsigned     FLUSH_CYCLES = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall_i,
    input  logic            br_taken_i,
    input  logic [XLEN-1:0] br_target_i,
    input  logic            jmp_i,
    input  logic [XLEN-1:0] jmp_target_i,
    input  logic            trap_i,
    input  logic [XLEN-1:0] trap_vec_i,
    input  logic            halt_i,
    input  logic            resume_i,
    output logic [XLEN-1:0] im_addr,
    output logic [XLEN-1:0] pc_o,
    output logic [XLEN-1:0] pc_next_o,
    output logic            fetch_valid_o,
    output logic            flush_o,
    output logic            misalign_o
);

    localparam logic [1:0] ST_BOOT  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;
    localparam logic [1:0] ST_HALT  = 2'd3;

    localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(INST_BYTES - 1);
    localparam logic [XLEN-1:0] PC_STEP    = XLEN'(INST_BYTES);
    localparam logic [2:0]      FLUSH_INIT = 3'(FLUSH_CYCLES);
    // With no bubbles configured, a redirect lands straight back in RUN.
    localparam logic [1:0]      REDIR_STATE = (FLUSH_CYCLES == 0) ? ST_RUN : ST_FLUSH;

    logic [1:0]      state_reg, state_next;
    logic [XLEN-1:0] pc_reg, pc_next;
    logic [2:0]      flush_cnt_reg, flush_cnt_next;
    logic            fetch_valid_reg, flush_reg, misalign_reg, misalign_next;

    logic [XLEN-1:0] jmp_tgt, trap_tgt, seq_pc;
    logic            jmp_bad, br_bad;

    // Target conditioning: jumps drop bit 0 and traps drop all sub-instruction bits.
    // Only jump and branch targets can be rejected.
    assign jmp_tgt  = {jmp_target_i[XLEN-1:1], 1'b0};
    assign trap_tgt = trap_vec_i & ~ALIGN_MASK;
    assign jmp_bad  = |(jmp_tgt & ALIGN_MASK);
    assign br_bad   = |(br_target_i & ALIGN_MASK);
    assign seq_pc   = pc_reg + PC_STEP;

    // Next-state, next-PC and flush-counter selection.
    always_comb begin
        state_next     = state_reg;
        pc_next        = pc_reg;
        flush_cnt_next = flush_cnt_reg;
        misalign_next  = 1'b0;
        case (state_reg)
            ST_BOOT: begin
                state_next = ST_RUN;
            end
            ST_RUN, ST_FLUSH: begin
                // Baseline progression when nothing redirects.
                // FLUSH counts down while RUN advances unless stalled.
                if (state_reg == ST_FLUSH) begin
                    if (flush_cnt_reg <= 3'd1) begin
                        state_next     = ST_RUN;
                        flush_cnt_next = 3'd0;
                    end else begin
                        flush_cnt_next = flush_cnt_reg - 3'd1;
                    end
                end else if (!stall_i) begin
                    pc_next = seq_pc;
                end

                if (trap_i) begin
                    // Trap wins over everything, including halt.
                    pc_next        = trap_tgt;
                    state_next     = REDIR_STATE;
                    flush_cnt_next = FLUSH_INIT;
                end else if (jmp_i || br_taken_i) begin
                    if ((jmp_i && jmp_bad) || (!jmp_i && br_bad)) begin
                        // Rejected redirect: PC frozen and the state is not disturbed.
                        pc_next       = pc_reg;
                        misalign_next = 1'b1;
                    end else begin
                        pc_next = jmp_i ? jmp_tgt : br_target_i;
                        if (halt_i) begin
                            // Redirect and halt together: park on the target without bubbles.
                            state_next     = ST_HALT;
                            flush_cnt_next = 3'd0;
                        end else begin
                            state_next     = REDIR_STATE;
                            flush_cnt_next = FLUSH_INIT;
                        end
                    end
                end else if (halt_i) begin
                    pc_next        = pc_reg;
                    state_next     = ST_HALT;
                    flush_cnt_next = 3'd0;
                end
            end
            ST_HALT: begin
                // Only a trap or a resume gets out of HALT.
                // Jump, branch and stall are ignored here.
                if (trap_i) begin
                    pc_next        = trap_tgt;
                    state_next     = REDIR_STATE;
                    flush_cnt_next = FLUSH_INIT;
                end else if (resume_i) begin
                    state_next = ST_RUN;
                end
            end
            default: begin
                state_next     = ST_BOOT;
                flush_cnt_next = 3'd0;
            end
        endcase
    end

    // State, PC and registered status outputs.
    // Async active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg       <= ST_BOOT;
            pc_reg          <= RESET_VECTOR;
            flush_cnt_reg   <= 3'd0;
            fetch_valid_reg <= 1'b0;
            flush_reg       <= 1'b0;
            misalign_reg    <= 1'b0;
        end else begin
            state_reg       <= state_next;
            pc_reg          <= pc_next;
            flush_cnt_reg   <= flush_cnt_next;
            fetch_valid_reg <= (state_next == ST_RUN);
            flush_reg       <= (state_next == ST_FLUSH);
            misalign_reg    <= misalign_next;
        end
    end

    assign pc_o          = pc_reg;
    assign im_addr       = pc_reg;
    assign pc_next_o     = seq_pc;
    assign fetch_valid_o = fetch_valid_reg;
    assign flush_o       = flush_reg;
    assign misalign_o    = misalign_reg;

endmodule

// File: tb/tb_pc_gen_unit.sv
// Testbench for pc_gen_unit.
// Each scenario queues stimulus with hand-derived expected outputs.
// It then replays the stimulus cycle by cycle and compares the outputs.
module tb_pc_gen_unit;

    typedef struct packed {
        logic        trap;
        logic [31:0] tv;
        logic        jmp;
        logic [31:0] jt;
        logic        br;
        logic [31:0] bt;
        logic        stall;
        logic        halt;
        logic        resume;
    } stim_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall_i = 1'b0, br_taken_i = 1'b0, jmp_i = 1'b0, trap_i = 1'b0;
    logic        halt_i = 1'b0, resume_i = 1'b0;
    logic [31:0] br_target_i = '0, jmp_target_i = '0, trap_vec_i = '0;
    logic [31:0] im_addr, pc_o, pc_next_o;
    logic        fetch_valid_o, flush_o, misalign_o;

    int checks = 0;
    int errors = 0;

    stim_t       stq[$];
    logic [98:0] sb[$];

    pc_gen_unit #(
        .XLEN(32), .RESET_VECTOR(32'h100), .INST_BYTES(4), .FLUSH_CYCLES(2)
    ) dut (
        .clk(clk), .rst(rst), .stall_i(stall_i),
        .br_taken_i(br_taken_i), .br_target_i(br_target_i),
        .jmp_i(jmp_i), .jmp_target_i(jmp_target_i),
        .trap_i(trap_i), .trap_vec_i(trap_vec_i),
        .halt_i(halt_i), .resume_i(resume_i),
        .im_addr(im_addr), .pc_o(pc_o), .pc_next_o(pc_next_o),
        .fetch_valid_o(fetch_valid_o), .flush_o(flush_o), .misalign_o(misalign_o)
    );

    always #5 clk = ~clk;

    function automatic stim_t st(logic tr, logic [31:0] tv, logic j, logic [31:0] jt,
                                 logic b, logic [31:0] bt, logic s, logic h, logic r);
        stim_t x;
        x.trap = tr; x.tv = tv; x.jmp = j; x.jt = jt; x.br = b; x.bt = bt;
        x.stall = s; x.halt = h; x.resume = r;
        return x;
    endfunction

    // Queue one cycle of stimulus and the outputs expected after that edge.
    task automatic add(input stim_t s, input logic [31:0] pc, input logic v, input logic f, input logic m);
        logic [31:0] nx;
        nx = pc + 32'd4;
        stq.push_back(s);
        sb.push_back({pc, pc, nx, v, f, m});
    endtask

    task automatic apply(input stim_t s);
        trap_i = s.trap; trap_vec_i = s.tv; jmp_i = s.jmp; jmp_target_i = s.jt;
        br_taken_i = s.br; br_target_i = s.bt; stall_i = s.stall;
        halt_i = s.halt; resume_i = s.resume;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [98:0] observed();
        return {pc_o, im_addr, pc_next_o, fetch_valid_o, flush_o, misalign_o};
    endfunction

    task automatic test_reset();
        logic [98:0] e, g;
        int n = 0;
        rst = 1'b1;
        #2 rst = 1'b0;
        #10;
        sb.push_back({32'h100, 32'h100, 32'h104, 1'b0, 1'b0, 1'b0});
        e = sb.pop_front(); g = observed(); checks++;
        if (g !== e) begin
            errors++;
            $display("FAIL reset_state: got %h expected %h", g, e);
        end
        rst = 1'b1;
        add(st(0,0,0,0,0,0,0,0,0), 32'h100, 1, 0, 0);
        add(st(0,0,0,0,0,0,0,0,0), 32'h104, 1, 0, 0);
        add(st(0,0,0,0,0,0,0,0,0), 32'h108, 1, 0, 0);
        while (stq.size() > 0) begin
            apply(stq.pop_front());
            cyc();
            e = sb.pop_front(); g = observed(); checks++; n++;
            if (g !== e) begin
                errors++;
                $display("FAIL boot_seq step %0d: got pc=%h v=%b f=%b m=%b (raw %h) expected %h", n, g[98:67], g[2], g[1], g[0], g, e);
            end
        end
        $display("test_reset done (%0d steps)", n + 1);
    endtask

    task automatic test_branch_flush();
        logic [98:0] e, g;
        int n = 0;
        add(st(0,0,0,0,1,32'h2000,0,0,0), 32'h2000, 0, 1, 0);
        add(st(0,0,0,0,0,0,0,0,0),        32'h2000, 0, 1, 0);
        add(st(0,0,0,0,0,0,0,0,0),        32'h2000, 1, 0, 0);
        add(st(0,0,0,0,0,0,0,0,0),        32'h2004, 1, 0, 0);
        while (stq.size() > 0) begin
            apply(stq.pop_front());
            cyc();
            e = sb.pop_front(); g = observed(); checks++; n++;
            if (g !== e) begin
                errors++;
                $display("FAIL branch_flush step %0d: got pc=%h v=%b f=%b m=%b (raw %h) expected %h", n, g[98:67], g[2], g[1], g[0], g, e);
            end
        end
        $display("test_branch_flush done (%0d steps)", n);
    endtask

    task automatic test_trap_priority();
        logic [98:0] e, g;
        int n = 0;
        add(st(1,32'h803,1,32'h3000,1,32'h4000,0,1,0), 32'h800, 0, 1, 0);
        add(st(0,0,0,0,0,0,0,0,0),                     32'h800, 0, 1, 0);
        add(st(0,0,0,0,0,0,0,0,0),                     32'h800, 1, 0, 0);
        add(st(0,0,0,0,0,0,0,0,0),                     32'h804, 1, 0, 0);
        while (stq.size() > 0) begin
            apply(stq.pop_front());
            cyc();
            e = sb.pop_front(); g = observed(); checks++; n++;
            if (g !== e) begin
                errors++;
                $display("FAIL trap_priority step %0d: got pc=%h v=%b f=%b m=%b (raw %h) expected %h", n, g[98:67], g[2], g[1], g[0], g, e);
            end
        end
        $display("test_trap_priority done (%0d steps)", n);
    endtask

    task automatic test_misalign();
        logic [98:0] e, g;
        int n = 0;
        add(st(0,0,1,32'h1002,0,0,0,0,0), 32'h804,  1, 0, 1);
        add(st(0,0,0,0,0,0,0,0,0),        32'h808,  1, 0, 0);
        add(st(0,0,1,32'h1001,0,0,0,0,0), 32'h1000, 0, 1, 0);
        add(st(0,0,0,0,0,0,0,0,0),        32'h1000, 0, 1, 0);
        add(st(0,0,0,0,0,0,0,0,0),        32'h1000, 1, 0, 0);
        add(st(0,0,0,0,1,32'h1006,0,0,0), 32'h1000, 1, 0, 1);
        add(st(0,0,0,0,0,0,0,0,0),        32'h1004, 1, 0, 0);
        while (stq.size() > 0) begin
            apply(stq.pop_front());
            cyc();
            e = sb.pop_front(); g = observed(); checks++; n++;
            if (g !== e) begin
                errors++;
                $display("FAIL misalign step %0d: got pc=%h v=%b f=%b m=%b (raw %h) expected %h", n, g[98:67], g[2], g[1], g[0], g, e);
            end
        end
        $display("test_misalign done (%0d steps)", n);
    endtask

    task automatic test_wrap_stall();
        logic [98:0] e, g;
        int n = 0;
        add(st(0,0,1,32'hFFFF_FFFC,0,0,0,0,0), 32'hFFFF_FFFC, 0, 1, 0);
        add(st(0,0,0,0,0,0,0,0,0),             32'hFFFF_FFFC, 0, 1, 0);
        add(st(0,0,0,0,0,0,0,0,0),             32'hFFFF_FFFC, 1, 0, 0);
        add(st(0,0,0,0,0,0,0,0,0),             32'h0,         1, 0, 0);
        for (int i = 0; i < 3; i++)
            add(st(0,0,0,0,0,0,1,0,0),         32'h0,         1, 0, 0);
        add(st(0,0,0,0,0,0,0,0,0),             32'h4,         1, 0, 0);
        while (stq.size() > 0) begin
            apply(stq.pop_front());
            cyc();
            e = sb.pop_front(); g = observed(); checks++; n++;
            if (g !== e) begin
                errors++;
                $display("FAIL wrap_stall step %0d: got pc=%h v=%b f=%b m=%b (raw %h) expected %h", n, g[98:67], g[2], g[1], g[0], g, e);
            end
        end
        $display("test_wrap_stall done (%0d steps)", n);
    endtask

    task automatic test_halt_resume();
        logic [98:0] e, g;
        int n = 0;
        add(st(0,0,0,0,0,0,0,1,0),          32'h4,   0, 0, 0);
        add(st(0,0,1,32'h40,0,0,0,0,0),     32'h4,   0, 0, 0);
        add(st(0,0,0,0,0,0,0,0,1),          32'h4,   1, 0, 0);
        add(st(0,0,0,0,0,0,0,0,0),          32'h8,   1, 0, 0);
        add(st(0,0,0,0,1,32'h500,0,1,0),    32'h500, 0, 0, 0);
        add(st(0,0,0,0,0,0,0,0,0),          32'h500, 0, 0, 0);
        add(st(1,32'h602,0,0,0,0,0,0,0),    32'h600, 0, 1, 0);
        add(st(0,0,0,0,0,0,0,0,0),          32'h600, 0, 1, 0);
        add(st(0,0,0,0,0,0,0,0,0),          32'h600, 1, 0, 0);
        add(st(0,0,0,0,0,0,0,0,0),          32'h604, 1, 0, 0);
        while (stq.size() > 0) begin
            apply(stq.pop_front());
            cyc();
            e = sb.pop_front(); g = observed(); checks++; n++;
            if (g !== e) begin
                errors++;
                $display("FAIL halt_resume step %0d: got pc=%h v=%b f=%b m=%b (raw %h) expected %h", n, g[98:67], g[2], g[1], g[0], g, e);
            end
        end
        $display("test_halt_resume done (%0d steps)", n);
    endtask

    task automatic test_back_to_back();
        logic [98:0] e, g;
        int n = 0;
        add(st(0,0,0,0,1,32'h700,0,0,0), 32'h700, 0, 1, 0);
        add(st(0,0,0,0,1,32'h900,0,0,0), 32'h900, 0, 1, 0);
        add(st(0,0,0,0,0,0,0,0,0),       32'h900, 0, 1, 0);
        add(st(0,0,0,0,0,0,0,0,0),       32'h900, 1, 0, 0);
        while (stq.size() > 0) begin
            apply(stq.pop_front());
            cyc();
            e = sb.pop_front(); g = observed(); checks++; n++;
            if (g !== e) begin
                errors++;
                $display("FAIL back_to_back step %0d: got pc=%h v=%b f=%b m=%b (raw %h) expected %h", n, g[98:67], g[2], g[1], g[0], g, e);
            end
        end
        $display("test_back_to_back done (%0d steps)", n);
    endtask

    task automatic test_reset_mid_flush();
        logic [98:0] e, g;
        add(st(0,0,0,0,1,32'hA00,0,0,0), 32'hA00, 0, 1, 0);
        apply(stq.pop_front());
        cyc();
        e = sb.pop_front(); g = observed(); checks++;
        if (g !== e) begin
            errors++;
            $display("FAIL mid_reset_setup: got %h expected %h", g, e);
        end
        apply(st(0,0,0,0,0,0,0,0,0));
        rst = 1'b0;
        #1;
        sb.push_back({32'h100, 32'h100, 32'h104, 1'b0, 1'b0, 1'b0});
        e = sb.pop_front(); g = observed(); checks++;
        if (g !== e) begin
            errors++;
            $display("FAIL mid_reset_async: got %h expected %h", g, e);
        end
        rst = 1'b1;
        add(st(0,0,0,0,0,0,0,0,0), 32'h100, 1, 0, 0);
        apply(stq.pop_front());
        cyc();
        e = sb.pop_front(); g = observed(); checks++;
        if (g !== e) begin
            errors++;
            $display("FAIL mid_reset_reboot: got %h expected %h", g, e);
        end
        $display("test_reset_mid_flush done");
    endtask

    initial begin
        test_reset();
        test_branch_flush();
        test_trap_priority();
        test_misalign();
        test_wrap_stall();
        test_halt_resume();
        test_back_to_back();
        test_reset_mid_flush();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
